// File: rtl/ovc_credit_status_ctrl_if.sv
// Event and status bundle between one router output port and its credit/status tracker.
// The router side drives grants, sends and credit returns; the tracker drives per-VC status.
interface ovc_credit_status_ctrl_if #(
    parameter int unsigned V  = 4,
    parameter int unsigned CW = 3
);
    logic [V-1:0]    ovc_allocated;
    logic            flit_sent_valid;
    logic [V-1:0]    flit_sent_vc_num;
    logic            flit_sent_is_tail;
    logic [V-1:0]    credit_in;
    logic [V-1:0]    ovc_is_free;
    logic [V-1:0]    ovc_not_full;
    logic [V*CW-1:0] ovc_credit_cnt;
    logic [3:0]      err_flags;

    modport master (
        output ovc_allocated,
        output flit_sent_valid,
        output flit_sent_vc_num,
        output flit_sent_is_tail,
        output credit_in,
        input  ovc_is_free,
        input  ovc_not_full,
        input  ovc_credit_cnt,
        input  err_flags
    );

    modport slave (
        input  ovc_allocated,
        input  flit_sent_valid,
        input  flit_sent_vc_num,
        input  flit_sent_is_tail,
        input  credit_in,
        output ovc_is_free,
        output ovc_not_full,
        output ovc_credit_cnt,
        output err_flags
    );
endinterface

// File: rtl/ovc_credit_status_ctrl.sv
// Per-output-VC allocation state and downstream credit tracking for one router output port.
// All status outputs come straight from registers so the allocator never sees a combinational path.
module ovc_credit_status_ctrl #(
    parameter int unsigned V                    = 4,
    parameter int unsigned B                    = 4,
    parameter int unsigned CONSERVATIVE_REALLOC = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    ovc_credit_status_ctrl_if.slave    bus
);
    localparam int unsigned CW = $clog2(B + 1);
    localparam logic [CW-1:0] BCnt = CW'(B);
    localparam bit Conservative = (CONSERVATIVE_REALLOC != 0);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StDrain  = 2'd2
    } vc_state_e;

    vc_state_e     state_q [V];
    vc_state_e     state_d [V];
    logic [CW-1:0] cnt_q   [V];
    logic [CW-1:0] cnt_d   [V];
    logic [3:0]    err_q;
    logic [3:0]    err_d;

    logic [V-1:0]  dec;
    logic [V-1:0]  inc;
    logic [V-1:0]  alloc;
    logic          tail;

    assign dec   = bus.flit_sent_vc_num & {V{bus.flit_sent_valid}};
    assign inc   = bus.credit_in;
    assign alloc = bus.ovc_allocated;
    assign tail  = bus.flit_sent_is_tail;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < V; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= BCnt;
            end
            err_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        err_d = err_q;
        for (int i = 0; i < V; i++) begin
            cnt_d[i]   = cnt_q[i];
            state_d[i] = state_q[i];

            // A send and a credit on the same VC cancel, so no boundary check applies.
            if (dec[i] && !inc[i]) begin
                if (cnt_q[i] == '0) begin
                    err_d[1] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end else if (inc[i] && !dec[i]) begin
                if (cnt_q[i] == BCnt) begin
                    err_d[0] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end

            case (state_q[i])
                StIdle: begin
                    if (alloc[i]) begin
                        // Grant and send together behave as an ACTIVE VC (single-flit packet).
                        if (dec[i] && tail) begin
                            state_d[i] = (!Conservative || cnt_d[i] == BCnt) ? StIdle : StDrain;
                        end else begin
                            state_d[i] = StActive;
                        end
                    end else if (dec[i]) begin
                        err_d[3] = 1'b1;
                    end
                end
                StActive: begin
                    if (alloc[i]) begin
                        err_d[2] = 1'b1;
                    end
                    if (dec[i] && tail) begin
                        state_d[i] = (!Conservative || cnt_d[i] == BCnt) ? StIdle : StDrain;
                    end
                end
                StDrain: begin
                    if (alloc[i]) begin
                        err_d[2] = 1'b1;
                    end
                    if (dec[i]) begin
                        err_d[3] = 1'b1;
                    end
                    if (cnt_d[i] == BCnt) begin
                        state_d[i] = StIdle;
                    end
                end
                default: state_d[i] = StIdle;
            endcase
        end
    end

    always_comb begin
        bus.ovc_is_free    = '0;
        bus.ovc_not_full   = '0;
        bus.ovc_credit_cnt = '0;
        for (int i = 0; i < V; i++) begin
            bus.ovc_is_free[i]              = (state_q[i] == StIdle);
            bus.ovc_not_full[i]             = (cnt_q[i] != '0);
            bus.ovc_credit_cnt[i*CW +: CW]  = cnt_q[i];
        end
        bus.err_flags = err_q;
    end
endmodule

// File: tb/tb_ovc_credit_status_ctrl.sv
// Scoreboard bench: one conservative and one eager-realloc instance share stimulus; a queue-based
// reference of credits and packet ownership predicts every registered output.
module tb_ovc_credit_status_ctrl;
    localparam int unsigned V  = 4;
    localparam int unsigned B  = 4;
    localparam int unsigned CW = $clog2(B + 1);

    typedef struct {
        logic [V-1:0]    free;
        logic [V-1:0]    nf;
        logic [V*CW-1:0] cnt;
        logic [3:0]      err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ovc_credit_status_ctrl_if #(.V(V), .CW(CW)) bus_c ();
    ovc_credit_status_ctrl_if #(.V(V), .CW(CW)) bus_e ();

    ovc_credit_status_ctrl #(.V(V), .B(B), .CONSERVATIVE_REALLOC(1)) dut_c (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_c)
    );

    ovc_credit_status_ctrl #(.V(V), .B(B), .CONSERVATIVE_REALLOC(0)) dut_e (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_e)
    );

    // Reference: model 0 is conservative, model 1 frees on tail.
    int       m_cnt   [2][V];
    bit       m_pkt   [2][V];
    bit       m_drain [2][V];
    bit [3:0] m_err   [2];

    exp_t q0[$];
    exp_t q1[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cycle   = 0;

    function automatic void model_step(int m, bit rst, logic [V-1:0] al, bit sv,
                                       logic [V-1:0] svc, bit tl, logic [V-1:0] cr);
        if (rst) begin
            for (int i = 0; i < V; i++) begin
                m_cnt[m][i]   = B;
                m_pkt[m][i]   = 0;
                m_drain[m][i] = 0;
            end
            m_err[m] = '0;
            return;
        end
        for (int i = 0; i < V; i++) begin
            bit snd;
            bit was_drain;
            int nxt;
            snd = sv && svc[i];
            was_drain = m_drain[m][i];
            nxt = m_cnt[m][i] + (cr[i] ? 1 : 0) - (snd ? 1 : 0);
            if (nxt < 0) begin
                nxt = 0;
                m_err[m][1] = 1'b1;
            end
            if (nxt > B) begin
                nxt = B;
                m_err[m][0] = 1'b1;
            end
            if (al[i]) begin
                if (!m_pkt[m][i] && !m_drain[m][i]) m_pkt[m][i] = 1;
                else m_err[m][2] = 1'b1;
            end
            if (snd) begin
                if (!m_pkt[m][i]) begin
                    m_err[m][3] = 1'b1;
                end else if (tl) begin
                    m_pkt[m][i]   = 0;
                    m_drain[m][i] = (m == 0) && (nxt != B);
                end
            end
            if (was_drain && nxt == B) m_drain[m][i] = 0;
            m_cnt[m][i] = nxt;
        end
    endfunction

    function automatic exp_t model_out(int m);
        exp_t e;
        e.cnt = '0;
        for (int i = 0; i < V; i++) begin
            e.free[i]          = !m_pkt[m][i] && !m_drain[m][i];
            e.nf[i]            = (m_cnt[m][i] != 0);
            e.cnt[i*CW +: CW]  = CW'(m_cnt[m][i]);
        end
        e.err = m_err[m];
        return e;
    endfunction

    task automatic step(input bit rst, input logic [V-1:0] al, input bit sv,
                        input logic [V-1:0] svc, input bit tl, input logic [V-1:0] cr);
        reset                   = rst;
        bus_c.ovc_allocated     = al;
        bus_e.ovc_allocated     = al;
        bus_c.flit_sent_valid   = sv;
        bus_e.flit_sent_valid   = sv;
        bus_c.flit_sent_vc_num  = svc;
        bus_e.flit_sent_vc_num  = svc;
        bus_c.flit_sent_is_tail = tl;
        bus_e.flit_sent_is_tail = tl;
        bus_c.credit_in         = cr;
        bus_e.credit_in         = cr;
        model_step(0, rst, al, sv, svc, tl, cr);
        model_step(1, rst, al, sv, svc, tl, cr);
        q0.push_back(model_out(0));
        q1.push_back(model_out(1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, '0, 0, '0, 0, '0);
    endtask

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endfunction

    // Monitor: registered outputs are compared 2 time units after each edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        cycle++;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("cons free", 32'(bus_c.ovc_is_free), 32'(e.free));
            check("cons not_full", 32'(bus_c.ovc_not_full), 32'(e.nf));
            check("cons cnt", 32'(bus_c.ovc_credit_cnt), 32'(e.cnt));
            check("cons err", 32'(bus_c.err_flags), 32'(e.err));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("eager free", 32'(bus_e.ovc_is_free), 32'(e.free));
            check("eager not_full", 32'(bus_e.ovc_not_full), 32'(e.nf));
            check("eager cnt", 32'(bus_e.ovc_credit_cnt), 32'(e.cnt));
            check("eager err", 32'(bus_e.err_flags), 32'(e.err));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [V-1:0] al;
        logic [V-1:0] svc;
        logic [V-1:0] cr;
        step(1, '0, 0, '0, 0, '0);
        idle(3);
        // VC1: 4-flit packet with no credits, then credits return one by one.
        step(0, 4'b0010, 0, '0, 0, '0);
        for (int k = 0; k < 4; k++) step(0, '0, 1, 4'b0010, k == 3, '0);
        for (int k = 0; k < 4; k++) step(0, '0, 0, '0, 0, 4'b0010);
        idle(2);
        // VC2: single-flit packet granted and sent in one cycle.
        step(0, 4'b0100, 1, 4'b0100, 1, '0);
        idle(1);
        // VC0: drain to zero, then cancelling send+credit, then underflow.
        step(0, 4'b0001, 0, '0, 0, '0);
        for (int k = 0; k < 4; k++) step(0, '0, 1, 4'b0001, 0, '0);
        step(0, '0, 1, 4'b0001, 0, 4'b0001);
        step(0, '0, 1, 4'b0001, 0, '0);
        idle(1);
        // VC3 idle at full credit: overflow.
        step(0, '0, 0, '0, 0, 4'b1000);
        idle(1);
        // Double grant on VC1.
        step(0, 4'b0010, 0, '0, 0, '0);
        step(0, 4'b0010, 0, '0, 0, '0);
        step(0, '0, 1, 4'b0010, 0, '0);
        // Reset in the middle of the VC1 packet.
        step(1, '0, 0, '0, 0, '0);
        idle(2);

        for (int k = 0; k < 600; k++) begin
            al  = '0;
            svc = '0;
            cr  = '0;
            if ($urandom_range(0, 3) == 0) al[$urandom_range(0, V - 1)] = 1'b1;
            svc[$urandom_range(0, V - 1)] = 1'b1;
            for (int i = 0; i < V; i++) begin
                if (m_cnt[0][i] < B && $urandom_range(0, 2) == 0) cr[i] = 1'b1;
                else if ($urandom_range(0, 63) == 0) cr[i] = 1'b1;
            end
            step($urandom_range(0, 59) == 0, al, $urandom_range(0, 1) == 1, svc,
                 $urandom_range(0, 2) == 0, cr);
        end
        idle(1);

        repeat (2) @(posedge clk);
        #3;
        n_tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL queue drain: %0d/%0d entries left, expected 0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
